bus_sram_responder: RTL and testbench
=====================================

// Module: bus_sram_responder
// PURPOSE
//  Bus-side responder (slave) for the shared burst bus driven by the DMA initiators. Maps an
//  internal single-port word SRAM into an address window; serves burst reads and burst writes,
//  inserts programmable write stalls via busy, and signals bus error on window overrun.
//  Used as the on-chip memory target for DMA block transfers and as the initiator test partner.
// PARAMETERS
//  baseAddress       32'h00000000  byte address of window start (word aligned)
//  nrOfWords         1024          window/SRAM size in 32-bit words (power of 2, 2..65536)
//  readLatency       2             cycles from beginTransaction sample to first read data (min 2)
//  writeStallCycles  0             busyOut-high cycles inserted after every accepted write word (0..15)
// PORTS
//  clock               in   1   single clock, all logic on rising edge
//  reset               in   1   asynchronous, active-high
//  beginTransactionIn  in   1   1-cycle start; addressDataIn holds byte address
//  readNotWriteIn      in   1   1 = read burst, 0 = write burst (valid with begin)
//  byteEnablesIn       in   4   write byte lanes, latched at begin, applied to every beat
//  burstSizeIn         in   8   beats minus 1, latched at begin
//  addressDataIn       in   32  address at begin, write data otherwise
//  dataValidIn         in   1   write beat present on addressDataIn
//  endTransactionIn    in   1   initiator ends/aborts current transaction
//  addressDataOut      out  32  read data; 0 when dataValidOut=0
//  dataValidOut        out  1   read beat valid
//  endTransactionOut   out  1   1-cycle end of read burst or error response
//  busyOut             out  1   write stall; beat not accepted while high
//  busErrorOut         out  1   1-cycle error indication
// BEHAVIOUR
//  Reset (async): state IDLE, every output 0, counters 0; SRAM contents NOT cleared.
//  All outputs registered. Hit: begin with addr in [base, base+4*nrOfWords); addr[1:0] ignored.
//  Miss: no response, stay IDLE. Overrun: hit but addr+4*burstSizeIn beyond window -> error.
//  Latch at begin: word index=(addr-base)>>2, beatCnt=burstSizeIn, byteEnables, direction.
//  States: IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, WR_STALL, ERR, ERR_WAIT.
//  IDLE: hit read -> RD_WAIT; hit write -> WR_DATA; overrun -> ERR; miss -> IDLE.
//  RD_WAIT: count readLatency-1 cycles (SRAM read issued early) -> RD_DATA.
//  RD_DATA: one beat per cycle, dataValidOut=1, index+1, beatCnt-1; first beat exactly
//    readLatency cycles after begin cycle; after beat with beatCnt=0 -> RD_END.
//  RD_END: endTransactionOut=1 for exactly the cycle after the last beat -> IDLE.
//  WR_DATA: beat accepted iff dataValidIn=1 and busyOut=0; writes enabled lanes at index,
//    index+1, beatCnt-1; if writeStallCycles>0 -> WR_STALL. Beats after burstSizeIn+1 ignored.
//  WR_STALL: busyOut=1 from cycle after acceptance for writeStallCycles cycles -> WR_DATA.
//    Initiator holds beat while busy; held beat accepted when busy drops.
//  endTransactionIn in WR_*: -> IDLE (early end legal; unwritten beats lost, no error).
//  endTransactionIn in RD_WAIT/RD_DATA: abort, -> IDLE, no further beats, no endTransactionOut.
//  ERR: busErrorOut=1 one cycle. Read: next cycle endTransactionOut=1 -> IDLE.
//    Write: -> ERR_WAIT, ignore data, busy 0, until endTransactionIn -> IDLE.
//  No SRAM write ever occurs for an errored transaction.
//  begin while not IDLE: ignored. beatCnt 8-bit, max burst 256 beats; index wraps mod nrOfWords
//    (unreachable after overrun check).
//  Reset mid-burst: immediate IDLE, outputs 0; already-written words retained.
// TESTING
//  Write base, burst 3, data 0x11..0x44, BE=F, stall 0 -> 4 beats accepted consecutively;
//    read base burst 3 -> data 0x11,0x22,0x33,0x44 at cycles 2..5, end at cycle 6.
//  Write BE=4'b0011 data 0xAABBCCDD over 0x12345678 at base+8 -> readback 0x1234CCDD.
//  writeStallCycles=2, 3-beat write -> busyOut high 2 cycles after each beat, all 3 words stored.
//  Read base+4*(nrOfWords-2) burst 3 -> busErrorOut 1 cycle, endTransactionOut next cycle, no data.
//  Begin at base-4 or base+4*nrOfWords -> no output toggles for 20 cycles.
//  Assert reset during beat 2 of 8-beat read -> outputs 0 same cycle; earlier words unchanged.

Source files
------------

// File: rtl/bus_sram_responder_if.sv
// Burst bus between a DMA initiator (master) and a memory responder (slave).
interface bus_sram_responder_if;
    logic        beginTransactionIn;
    logic        readNotWriteIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic [31:0] addressDataIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busyOut;
    logic        busErrorOut;

    modport master (
        output beginTransactionIn, readNotWriteIn, byteEnablesIn, burstSizeIn,
               addressDataIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
    );

    modport slave (
        input  beginTransactionIn, readNotWriteIn, byteEnablesIn, burstSizeIn,
               addressDataIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
    );
endinterface

// File: rtl/bus_sram_responder.sv
// Burst-bus responder mapping a single-port word SRAM into an address window.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for beginTransactionIn
// RD_WAIT  | read latency countdown, first SRAM word being fetched
// RD_DATA  | one read beat presented per cycle
// RD_END   | endTransactionOut pulse (after last beat or read error)
// WR_DATA  | ready to accept a write beat
// WR_STALL | busyOut high after an accepted beat
// ERR      | busErrorOut pulse for a window overrun
// ERR_WAIT | errored write, swallowing beats until endTransactionIn
module bus_sram_responder #(
    parameter logic [31:0] baseAddress      = 32'h0000_0000,
    parameter int          nrOfWords        = 1024,
    parameter int          readLatency      = 2,
    parameter int          writeStallCycles = 0
) (
    input logic clock,
    input logic reset,
    bus_sram_responder_if.slave bus
);
    localparam int          indexWidth   = $clog2(nrOfWords);
    localparam logic [31:0] windowWords  = 32'(nrOfWords);
    localparam logic [31:0] windowBytes  = 32'(nrOfWords) << 2;
    localparam logic [7:0]  waitLoad     = 8'(readLatency - 2);
    localparam logic        stallEnabled = (writeStallCycles > 0);
    localparam logic [3:0]  stallLoad    = (writeStallCycles > 0) ? 4'(writeStallCycles - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_DATA, RD_END, WR_DATA, WR_STALL, ERR, ERR_WAIT
    } stateType;

    stateType state, nextState;

    logic [indexWidth-1:0] wordIndex, beginIndex, sramAddr;
    logic [7:0]  beatCnt;
    logic [3:0]  byteEnables;
    logic        isRead;
    logic        writesDone;
    logic [7:0]  waitCnt;
    logic [3:0]  stallCnt;
    logic [31:0] readWord;

    logic [32:0] offset;
    logic [31:0] lastWord;
    logic        hit, fits;
    logic        beatAccept, beatLoad;

    logic [31:0] addressDataReg, addressDataNext;
    logic        dataValidReg, dataValidNext;
    logic        endReg, endNext;
    logic        busyReg, busyNext;
    logic        errorReg, errorNext;

    logic [31:0] sram [nrOfWords];

    // Window decode of the begin address; borrow bit flags addresses below the base.
    assign offset     = {1'b0, bus.addressDataIn} - {1'b0, baseAddress};
    assign lastWord   = {2'b00, offset[31:2]} + {24'b0, bus.burstSizeIn};
    assign hit        = !offset[32] && (offset[31:0] < windowBytes);
    assign fits       = lastWord < windowWords;
    assign beginIndex = offset[indexWidth+1:2];

    // busyReg is always low in WR_DATA; kept in the term so acceptance reads like the bus rule.
    assign beatAccept = (state == WR_DATA) && bus.dataValidIn && !busyReg && !writesDone;
    assign beatLoad   = (nextState == RD_DATA);

    // Next-state decision.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.beginTransactionIn && hit) begin
                    if (!fits)                   nextState = ERR;
                    else if (bus.readNotWriteIn) nextState = RD_WAIT;
                    else                         nextState = WR_DATA;
                end
            end
            RD_WAIT: begin
                if (bus.endTransactionIn) nextState = IDLE;
                else if (waitCnt == 8'd0) nextState = RD_DATA;
            end
            RD_DATA: begin
                if (bus.endTransactionIn) nextState = IDLE;
                else if (beatCnt == 8'd0) nextState = RD_END;
            end
            RD_END: nextState = IDLE;
            WR_DATA: begin
                if (bus.endTransactionIn)           nextState = IDLE;
                else if (beatAccept && stallEnabled) nextState = WR_STALL;
            end
            WR_STALL: begin
                if (bus.endTransactionIn)  nextState = IDLE;
                else if (stallCnt == 4'd0) nextState = WR_DATA;
            end
            ERR: begin
                if (isRead)                    nextState = RD_END;
                else if (bus.endTransactionIn) nextState = IDLE;
                else                           nextState = ERR_WAIT;
            end
            ERR_WAIT: begin
                if (bus.endTransactionIn) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        dataValidNext   = (nextState == RD_DATA);
        addressDataNext = dataValidNext ? readWord : 32'd0;
        endNext         = (nextState == RD_END);
        busyNext        = (nextState == WR_STALL);
        errorNext       = (nextState == ERR);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            addressDataReg <= 32'd0;
            dataValidReg   <= 1'b0;
            endReg         <= 1'b0;
            busyReg        <= 1'b0;
            errorReg       <= 1'b0;
        end else begin
            state          <= nextState;
            addressDataReg <= addressDataNext;
            dataValidReg   <= dataValidNext;
            endReg         <= endNext;
            busyReg        <= busyNext;
            errorReg       <= errorNext;
        end
    end

    // Transaction context: word index, beat/latency/stall down-counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wordIndex   <= '0;
            beatCnt     <= 8'd0;
            byteEnables <= 4'd0;
            isRead      <= 1'b0;
            writesDone  <= 1'b0;
            waitCnt     <= 8'd0;
            stallCnt    <= 4'd0;
        end else begin
            if (state == IDLE && bus.beginTransactionIn) begin
                wordIndex   <= beginIndex;
                beatCnt     <= bus.burstSizeIn;
                byteEnables <= bus.byteEnablesIn;
                isRead      <= bus.readNotWriteIn;
                writesDone  <= 1'b0;
                waitCnt     <= waitLoad;
            end
            if (state == RD_WAIT && waitCnt != 8'd0) begin
                waitCnt <= waitCnt - 8'd1;
            end
            if (beatLoad) begin
                wordIndex <= wordIndex + indexWidth'(1);
                if (state == RD_DATA) beatCnt <= beatCnt - 8'd1;
            end
            if (beatAccept) begin
                wordIndex <= wordIndex + indexWidth'(1);
                stallCnt  <= stallLoad;
                if (beatCnt == 8'd0) writesDone <= 1'b1;
                else                 beatCnt    <= beatCnt - 8'd1;
            end
            if (state == WR_STALL && stallCnt != 4'd0) begin
                stallCnt <= stallCnt - 4'd1;
            end
        end
    end

    // The SRAM read runs one word ahead of the beat being presented so the output
    // register always finds the next word ready; in IDLE it prefetches the begin word.
    always_comb begin
        sramAddr = wordIndex;
        if (state == IDLE)  sramAddr = beginIndex;
        else if (beatLoad)  sramAddr = wordIndex + indexWidth'(1);
    end

    // Single-port SRAM: byte-lane write on an accepted beat, otherwise a read.
    always_ff @(posedge clock) begin
        if (beatAccept) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (byteEnables[lane]) sram[wordIndex][lane*8 +: 8] <= bus.addressDataIn[lane*8 +: 8];
            end
        end else begin
            readWord <= sram[sramAddr];
        end
    end

    assign bus.addressDataOut    = addressDataReg;
    assign bus.dataValidOut      = dataValidReg;
    assign bus.endTransactionOut = endReg;
    assign bus.busyOut           = busyReg;
    assign bus.busErrorOut       = errorReg;
endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed bench: a per-cycle timeline of expected outputs is built from the bus
// rules and a word-array memory model, and compared against two responders
// (no write stall and a 2-cycle write stall) on every falling edge.
module tb_bus_sram_responder;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WORDS = 64;
    localparam int          LAT   = 2;
    localparam int          MAXC  = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        beginV [2];
    logic        rnwV   [2];
    logic [3:0]  beV    [2];
    logic [7:0]  burstV [2];
    logic [31:0] adV    [2];
    logic        dvV    [2];
    logic        endV   [2];

    logic [31:0] gotData  [2];
    logic        gotValid [2];
    logic        gotEnd   [2];
    logic        gotBusy  [2];
    logic        gotErr   [2];

    bus_sram_responder_if bus0();
    bus_sram_responder_if bus1();

    assign bus0.beginTransactionIn = beginV[0];
    assign bus0.readNotWriteIn     = rnwV[0];
    assign bus0.byteEnablesIn      = beV[0];
    assign bus0.burstSizeIn        = burstV[0];
    assign bus0.addressDataIn      = adV[0];
    assign bus0.dataValidIn        = dvV[0];
    assign bus0.endTransactionIn   = endV[0];
    assign gotData[0]  = bus0.addressDataOut;
    assign gotValid[0] = bus0.dataValidOut;
    assign gotEnd[0]   = bus0.endTransactionOut;
    assign gotBusy[0]  = bus0.busyOut;
    assign gotErr[0]   = bus0.busErrorOut;

    assign bus1.beginTransactionIn = beginV[1];
    assign bus1.readNotWriteIn     = rnwV[1];
    assign bus1.byteEnablesIn      = beV[1];
    assign bus1.burstSizeIn        = burstV[1];
    assign bus1.addressDataIn      = adV[1];
    assign bus1.dataValidIn        = dvV[1];
    assign bus1.endTransactionIn   = endV[1];
    assign gotData[1]  = bus1.addressDataOut;
    assign gotValid[1] = bus1.dataValidOut;
    assign gotEnd[1]   = bus1.endTransactionOut;
    assign gotBusy[1]  = bus1.busyOut;
    assign gotErr[1]   = bus1.busErrorOut;

    bus_sram_responder #(.baseAddress(BASE), .nrOfWords(WORDS), .readLatency(LAT), .writeStallCycles(0))
        dut0 (.clock(clock), .reset(reset), .bus(bus0));
    bus_sram_responder #(.baseAddress(BASE), .nrOfWords(WORDS), .readLatency(LAT), .writeStallCycles(2))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));

    logic        expValid [2][MAXC];
    logic [31:0] expData  [2][MAXC];
    logic        expEnd   [2][MAXC];
    logic        expBusy  [2][MAXC];
    logic        expErr   [2][MAXC];
    logic [31:0] modelMem [2][WORDS];

    int   checks = 0;
    int   errors = 0;
    logic checking = 1'b0;

    function automatic int stallOf(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic longint wide(input logic [31:0] a);
        return longint'({32'b0, a});
    endfunction

    function automatic bit inWindow(input logic [31:0] addr);
        return (wide(addr) >= wide(BASE)) && (wide(addr) < wide(BASE) + 4 * WORDS);
    endfunction

    function automatic int wordOf(input logic [31:0] addr);
        return int'((wide(addr) - wide(BASE)) >>> 2);
    endfunction

    function automatic bit fitsWindow(input logic [31:0] addr, input int nBeats);
        return (wordOf(addr) + nBeats - 1) < WORDS;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Every output of both responders against the timeline, once per cycle.
    always @(negedge clock) begin
        if (checking && cyc < MAXC) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("valid dut%0d cycle %0d", i, cyc), 32'(gotValid[i]), 32'(expValid[i][cyc]));
                check($sformatf("data dut%0d cycle %0d", i, cyc), gotData[i], expData[i][cyc]);
                check($sformatf("end dut%0d cycle %0d", i, cyc), 32'(gotEnd[i]), 32'(expEnd[i][cyc]));
                check($sformatf("busy dut%0d cycle %0d", i, cyc), 32'(gotBusy[i]), 32'(expBusy[i][cyc]));
                check($sformatf("error dut%0d cycle %0d", i, cyc), 32'(gotErr[i]), 32'(expErr[i][cyc]));
            end
        end
    end

    task automatic clearFrom(input int from);
        for (int i = 0; i < 2; i++) begin
            for (int c = from; c < MAXC; c++) begin
                expValid[i][c] = 1'b0;
                expData[i][c]  = 32'd0;
                expEnd[i][c]   = 1'b0;
                expBusy[i][c]  = 1'b0;
                expErr[i][c]   = 1'b0;
            end
        end
    endtask

    // Read burst; resetAt > 0 asserts reset that many cycles after the begin cycle.
    task automatic doRead(input int i, input logic [31:0] addr, input int nBeats,
                          input int resetAt, output int b);
        b = cyc;
        beginV[i] = 1'b1;
        rnwV[i]   = 1'b1;
        beV[i]    = 4'h0;
        burstV[i] = 8'(nBeats - 1);
        adV[i]    = addr;
        if (inWindow(addr)) begin
            if (!fitsWindow(addr, nBeats)) begin
                expErr[i][b + 1] = 1'b1;
                expEnd[i][b + 2] = 1'b1;
            end else begin
                for (int k = 0; k < nBeats; k++) begin
                    expValid[i][b + LAT + k] = 1'b1;
                    expData[i][b + LAT + k]  = modelMem[i][wordOf(addr) + k];
                end
                expEnd[i][b + LAT + nBeats] = 1'b1;
            end
        end
        step(1);
        beginV[i] = 1'b0;
        rnwV[i]   = 1'b0;
        adV[i]    = 32'd0;
        if (resetAt > 0) begin
            step(resetAt - 1);
            reset = 1'b1;
            clearFrom(cyc);
            step(1);
            reset = 1'b0;
            step(2);
        end else begin
            step(LAT + nBeats + 1);
        end
    endtask

    // Write burst; the initiator presents each next beat right away and holds it while busy.
    task automatic doWrite(input int i, input logic [31:0] addr, input logic [3:0] be,
                           input int nBeats, input int nExtra,
                           input logic [31:0] d0, input logic [31:0] dStep);
        int c, idx, s;
        bit ok, prevAccepted;
        logic [31:0] d;
        s   = stallOf(i);
        ok  = inWindow(addr) && fitsWindow(addr, nBeats);
        idx = ok ? wordOf(addr) : 0;
        if (inWindow(addr) && !ok) expErr[i][cyc + 1] = 1'b1;
        beginV[i] = 1'b1;
        rnwV[i]   = 1'b0;
        beV[i]    = be;
        burstV[i] = 8'(nBeats - 1);
        adV[i]    = addr;
        step(1);
        beginV[i] = 1'b0;
        prevAccepted = 1'b0;
        for (int k = 0; k < nBeats + nExtra; k++) begin
            d = d0 + dStep * 32'(k);
            dvV[i] = 1'b1;
            adV[i] = d;
            if (prevAccepted) step(s);
            c = cyc;
            prevAccepted = ok && (k < nBeats);
            if (prevAccepted) begin
                for (int l = 0; l < 4; l++) begin
                    if (be[l]) modelMem[i][idx + k][8*l +: 8] = d[8*l +: 8];
                end
                for (int j = 1; j <= s; j++) expBusy[i][c + j] = 1'b1;
            end
            step(1);
        end
        dvV[i] = 1'b0;
        adV[i] = 32'd0;
        if (prevAccepted) step(s);
        endV[i] = 1'b1;
        step(1);
        endV[i] = 1'b0;
    endtask

    initial begin
        int b, bc, busyCount;
        for (int i = 0; i < 2; i++) begin
            beginV[i] = 1'b0; rnwV[i] = 1'b0; beV[i] = 4'h0; burstV[i] = 8'd0;
            adV[i] = 32'd0; dvV[i] = 1'b0; endV[i] = 1'b0;
        end
        clearFrom(0);
        step(3);
        reset = 1'b0;
        checking = 1'b1;
        step(2);

        // Back-to-back 4-beat write, then read back with latency 2.
        doWrite(0, BASE, 4'hF, 4, 0, 32'h11, 32'h11);
        doRead(0, BASE, 4, 0, b);
        check("pin read beat0", expData[0][b + 2], 32'h11);
        check("pin read beat3", expData[0][b + 5], 32'h44);
        check("pin read end", 32'(expEnd[0][b + 6]), 32'd1);
        check("pin read no early beat", 32'(expValid[0][b + 1]), 32'd0);

        // Partial-lane write over a known word; an extra beat past the burst must be dropped.
        doWrite(0, BASE + 8, 4'hF, 1, 0, 32'h1234_5678, 32'h0);
        doWrite(0, BASE + 8, 4'b0011, 1, 1, 32'hAABB_CCDD, 32'h1111_1111);
        doRead(0, BASE + 8, 2, 0, b);
        check("pin byte lanes", expData[0][b + 2], 32'h1234_CCDD);
        check("pin extra beat dropped", expData[0][b + 3], 32'h44);

        // Two stall cycles after each of three beats.
        bc = cyc;
        doWrite(1, BASE, 4'hF, 3, 0, 32'hA0A0_0001, 32'h0101_0101);
        busyCount = 0;
        for (int c = bc; c <= cyc; c++) if (expBusy[1][c]) busyCount++;
        check("pin stall cycles", 32'(busyCount), 32'd6);
        doRead(1, BASE, 3, 0, b);
        check("pin stalled word2", expData[1][b + 4], 32'hA2A2_0203);

        // Burst ending exactly on the last window word, then overruns.
        doWrite(0, BASE + 4*60, 4'hF, 4, 0, 32'hC0, 32'h1);
        doRead(0, BASE + 4*60, 4, 0, b);
        doRead(0, BASE + 4*(WORDS-2), 3, 0, b);
        check("pin overrun error", 32'(expErr[0][b + 1]), 32'd1);
        check("pin overrun end", 32'(expEnd[0][b + 2]), 32'd1);
        check("pin overrun no data", 32'(expValid[0][b + 2]), 32'd0);
        doWrite(0, BASE + 4*(WORDS-2), 4'hF, 4, 0, 32'hEE, 32'h1);
        doRead(0, BASE + 4*(WORDS-2), 2, 0, b);
        check("pin errored write kept", expData[0][b + 3], 32'hC3);

        // Addresses just outside the window: silence.
        doRead(0, BASE - 4, 1, 0, b);
        step(20);
        doWrite(0, BASE + 4*WORDS, 4'hF, 1, 0, 32'hDEAD_0000, 32'h0);
        step(20);
        doRead(0, BASE, 1, 0, b);
        check("pin miss write no wrap", expData[0][b + 2], 32'h11);

        // Reset during the second beat of an 8-beat read; memory survives.
        doWrite(0, BASE + 32, 4'hF, 8, 0, 32'h100, 32'h101);
        doRead(0, BASE + 32, 8, 3, b);
        doRead(0, BASE + 32, 8, 0, b);
        check("pin after reset last", expData[0][b + 9], 32'h807);
        doRead(0, BASE, 4, 0, b);
        check("pin after reset lanes", expData[0][b + 4], 32'h1234_CCDD);

        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
